// File: rtl/norm_skew_array.sv
// norm_skew_array
//   Per-channel normalisation stage between the systolic matmul output and
//   the pool/activation stages. Each enabled lane computes
//     out = sat((x - mean) * inv_var >>> SHIFT)
//   on column-skewed input: lane i carries data i cycles after lane 0.
//   A start/done FSM latches the run parameters and counts rows that leave
//   the last lane.
//
// Ports
//   clk            rising-edge clock
//   resetn         asynchronous active-low reset
//   start          one-cycle start pulse, accepted in IDLE or DONE
//   enable_norm    1 = normalise, 0 = bypass (latched at start)
//   mean           signed mean (latched at start)
//   inv_var        unsigned inverse variance, SHIFT fractional bits (latched)
//   num_rows       rows expected on the last lane (latched at start)
//   validity_mask  per-lane normalise enable (latched at start)
//   in_valid       lane-0 data valid; lane i is valid i cycles later
//   inp_data       lane i at [i*DWIDTH +: DWIDTH]
//   out_data       results, same packing, held between valids
//   out_valid_vec  per-lane output valid, still skewed
//   busy           high while running
//   done           high once the expected rows have left the last lane
module norm_skew_array #(
  parameter int NUM_CH = 8,
  parameter int DWIDTH = 8,
  parameter int SHIFT  = 0,
  parameter int RWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       enable_norm,
  input  logic signed [DWIDTH-1:0]   mean,
  input  logic [DWIDTH-1:0]          inv_var,
  input  logic [RWIDTH-1:0]          num_rows,
  input  logic [NUM_CH-1:0]          validity_mask,
  input  logic                       in_valid,
  input  logic [NUM_CH*DWIDTH-1:0]   inp_data,
  output logic [NUM_CH*DWIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]          out_valid_vec,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = 2*DWIDTH + 2;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic signed [DWIDTH-1:0] mean_q;
  logic [DWIDTH-1:0]        inv_var_q;
  logic [RWIDTH-1:0]        num_rows_q;
  logic [NUM_CH-1:0]        mask_q;
  logic                     en_q;
  logic [RWIDTH-1:0]        row_cnt;
  logic [RWIDTH:0]          cnt_inc;

  // v[0] is the gated input valid; v[i] (i>0) are registered copies of v[i-1].
  logic [NUM_CH-1:0]        v;
  logic [NUM_CH-1:0]        v_q;
  // Mirrors the lane-0 valid all the way to the last-lane output, but is
  // cleared on an accepted start so leftovers of a previous run never count.
  logic [NUM_CH:0]          tag_q;

  logic signed [DWIDTH:0]   d_p1 [NUM_CH];
  logic [NUM_CH-1:0]        vld_p1;
  logic [NUM_CH-1:0]        pass_p1;

  function automatic logic signed [DWIDTH:0] stage1(input logic [DWIDTH-1:0] x,
                                                    input logic signed [DWIDTH-1:0] m,
                                                    input logic pass);
    logic signed [DWIDTH:0] xe;
    logic signed [DWIDTH:0] me;
    xe = {x[DWIDTH-1], x};
    me = {m[DWIDTH-1], m};
    return pass ? xe : xe - me;
  endfunction

  function automatic logic [DWIDTH-1:0] scale_sat(input logic signed [DWIDTH:0] d,
                                                  input logic [DWIDTH-1:0] iv);
    logic signed [PW-1:0] de;
    logic signed [PW-1:0] ie;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    de = PW'(d);
    ie = PW'($signed({1'b0, iv}));
    p  = de * ie;
    r  = p >>> SHIFT;
    if (r > SAT_MAX)      return SAT_MAX[DWIDTH-1:0];
    else if (r < SAT_MIN) return SAT_MIN[DWIDTH-1:0];
    else                  return r[DWIDTH-1:0];
  endfunction

  always_comb begin
    v    = v_q;
    v[0] = in_valid && (state == RUN);
  end

  assign cnt_inc = {1'b0, row_cnt} + (RWIDTH+1)'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q <= '0;
    end else begin
      v_q[0] <= 1'b0;
      for (int i = 1; i < NUM_CH; i++) v_q[i] <= v[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mean_q     <= '0;
      inv_var_q  <= '0;
      num_rows_q <= '0;
      mask_q     <= '0;
      en_q       <= 1'b0;
      row_cnt    <= '0;
      tag_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tag_q <= {tag_q[NUM_CH-1:0], v[0]};
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mean_q     <= mean;
            inv_var_q  <= inv_var;
            num_rows_q <= num_rows;
            mask_q     <= validity_mask;
            en_q       <= enable_norm;
            row_cnt    <= '0;
            tag_q      <= '0;
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RUN: begin
          if (num_rows_q == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tag_q[NUM_CH]) begin
            // cnt_inc[RWIDTH] set means the counter is already all-ones
            if (!cnt_inc[RWIDTH]) row_cnt <= cnt_inc[RWIDTH-1:0];
            if (cnt_inc == {1'b0, num_rows_q}) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) d_p1[i] <= '0;
      vld_p1        <= '0;
      pass_p1       <= '0;
      out_valid_vec <= '0;
      out_data      <= '0;
    end else begin
      // stage 1: centre the sample (or sign-extend it when passing through)
      vld_p1 <= v;
      for (int i = 0; i < NUM_CH; i++) begin
        if (v[i]) begin
          pass_p1[i] <= ~(en_q & mask_q[i]);
          d_p1[i]    <= stage1(inp_data[i*DWIDTH +: DWIDTH], mean_q, ~(en_q & mask_q[i]));
        end
      end
      // stage 2: scale, shift, saturate; lanes hold their value between valids
      out_valid_vec <= vld_p1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (vld_p1[i]) begin
          out_data[i*DWIDTH +: DWIDTH] <= pass_p1[i] ? d_p1[i][DWIDTH-1:0]
                                                     : scale_sat(d_p1[i], inv_var_q);
        end
      end
    end
  end

endmodule

// File: doc/norm_skew_array.md
Name: norm_skew_array

Overview:
Parametrised per-channel normalisation stage. It sits between the systolic matmul output and the pool/activation stages. Each channel applies out = sat((x - mean) * inv_var >>> SHIFT). Input data arrives column-skewed (channel i lags channel 0 by i cycles); the block aligns valids internally and counts rows to raise done. This generalises the fixed 8-lane norm: it adds parametrised channel count and width, signed fixed-point scaling with saturation, a start/done FSM, and parameters latched at start.

Parameters:
NUM_CH, 8, number of channels (lanes); at least 1.
DWIDTH, 8, data width; data and mean are signed two's-complement, inv_var is unsigned.
SHIFT, 0, arithmetic right shift applied to the product (number of fractional bits in inv_var); 0 to 2*DWIDTH-1.
RWIDTH, 16, width of the row counter and of num_rows.

Ports:
clk  in  1  clock, all flops on rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
enable_norm  in  1  1 = normalise, 0 = bypass; latched at start.
mean  in  DWIDTH  signed mean; latched at start.
inv_var  in  DWIDTH  unsigned inverse variance; latched at start.
num_rows  in  RWIDTH  rows expected on the last channel; latched at start.
validity_mask  in  NUM_CH  per-channel enable; latched at start.
in_valid  in  1  channel-0 data valid; channel i data is valid i cycles later.
inp_data  in  NUM_CH*DWIDTH  flattened; channel i occupies bits [i*DWIDTH +: DWIDTH].
out_data  out  NUM_CH*DWIDTH  flattened results, same packing.
out_valid_vec  out  NUM_CH  per-channel output valid (output stays skewed).
busy  out  1  high in RUN.
done  out  1  high in DONE.

Behaviour:
- Reset (resetn=0, async): FSM=IDLE; all latched params, valid delay line, pipeline regs, row counter, out_data, out_valid_vec, busy and done = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start: latch mean, inv_var, num_rows, mask, mode; clear row counter; go to RUN (done drops the same edge).
  - RUN: if num_rows==0, go to DONE next cycle. Otherwise go to DONE on the edge where out_valid_vec[NUM_CH-1] is high and counter+1 == num_rows.
  - start while in RUN is ignored.
  - in_valid outside RUN is ignored: no pipeline activity, no outputs.
- Valid skew: v[0] = in_valid gated by RUN; v[i] = v[i-1] delayed one cycle. Channel i samples inp_data[i] when v[i]=1.
- Pipeline, 2 cycles per channel:
  - S1 when v[i]: d = x - mean, width DWIDTH+1 signed, no overflow.
  - S2 (one cycle later): p = d * {0,inv_var}, signed, 2*DWIDTH+2 bits; r = p >>> SHIFT; saturate r to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - out_valid_vec[i] is high exactly 2 cycles after v[i].
  - Channel NUM_CH-1 output first appears NUM_CH+1 cycles after in_valid.
- Masked channel (mask[i]=0) or bypass (enable_norm=0): S1 holds sign-extended x; S2 outputs x unchanged. Latency is identical, and valids are generated normally.
- Between valids, out_data lanes hold their last value.
- Back-to-back in_valid is supported at one row per cycle; no stalls, no backpressure.
- Once DONE is entered, trailing v[] entries still drain and outputs still update, but they are not counted. Valid entries already in flight when start is accepted are also not counted.
- Row counter counts last-channel output valids only and saturates at 2^RWIDTH-1.
- Changes to mean, inv_var, mask or enable_norm during RUN have no effect.

Test Plan:
1. DWIDTH=8, SHIFT=2, NUM_CH=8, mean=4, inv_var=3, start, then 4 back-to-back rows of x=20 on all lanes with num_rows=4 -> each out_data lane = 12. out_valid_vec[i] first high at cycle t0+2+i. done rises the edge after the 4th out_valid_vec[7]; busy falls the same edge.
2. Saturation, SHIFT=0: x=100, mean=-50, inv_var=2 -> 127; x=-100, mean=50, inv_var=2 -> -128; x=-1, mean=0, inv_var=0 -> 0.
3. Mask 8'b1010_1010, enable_norm=1, x=20, mean=4, inv_var=3, SHIFT=2 -> odd lanes = 12, even lanes = 20. enable_norm=0 -> all lanes = 20, same latency.
4. Latching: start with mean=4, then change mean to 10 mid-RUN -> outputs still use 4. Pulse start in RUN -> ignored, counter not cleared. in_valid while in IDLE -> no out_valid_vec activity.
5. num_rows=0 -> done one cycle after start. Restart from DONE with num_rows=2 -> done clears on start, re-asserts after 2 rows.
6. Drop resetn asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately. After release, FSM is IDLE and the next start runs normally.
